iob_rr_merge: RTL



---
 rtl/iob_rr_merge_pkg.sv | 35 +++
 rtl/iob_rr_prio_sel.sv | 51 +++++
 rtl/iob_rr_merge.sv | 106 ++++++++++
 3 files changed

// File: rtl/iob_rr_merge_pkg.sv
// Shared definitions for the IOb round-robin merge.
//   state_t      : arbiter FSM encoding (IDLE / BUSY)
//   req_width    : packed request width  {valid, address, wdata, wstrb}
//   resp_width   : packed response width {rdata, ready}
//   idx_width    : width of a master index (at least 1 bit)
//   valid_bit    : bit position of master i's valid inside the packed m_req bus
//   ready_bit    : bit position of master i's ready inside the packed m_resp bus
package iob_rr_merge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int valid_bit(input int i, input int req_w);
    return i * req_w + req_w - 1;
  endfunction

  function automatic int ready_bit(input int i, input int resp_w);
    return i * resp_w;
  endfunction

endpackage

// File: rtl/iob_rr_prio_sel.sv
// Combinational round-robin priority selector.
//   req     : one request bit per master
//   last    : index of the master served most recently
//   any_req : at least one request is pending
//   sel     : first requesting index scanning last+1, last+2, ... modulo N
// The request vector is rotated so that last+1 lands on bit 0, a fixed
// priority encoder picks the lowest set bit, and the result is rotated back.
module iob_rr_prio_sel #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any_req,
  output logic [IW-1:0] sel
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sh;
  logic [IW:0]    pos;
  logic [IW:0]    sum;
  logic           hit;

  always_comb begin
    // last <= N-1, so the shift amount is at most N; shifting the doubled
    // vector by N yields req again, which removes the need for a modulo.
    sh  = {1'b0, last} + 1'b1;
    dbl = {req, req};
    rot = N'(dbl >> sh);

    hit = 1'b0;
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && rot[i]) begin
        hit = 1'b1;
        pos = (IW+1)'(i);
      end
    end

    // Un-rotate: sum < 2N always, so one conditional subtract is enough.
    sum = sh + pos;
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end

    any_req = |req;
    sel     = sum[IW-1:0];
  end

endmodule

// File: rtl/iob_rr_merge.sv
// Round-robin N-master to 1-slave arbiter for the IOb native bus.
//   clk, rst  : clock, synchronous active-high reset
//   m_req     : packed master requests, master i in slice i, {valid, address, wdata, wstrb}
//   m_resp    : packed master responses, master i in slice i, {rdata, ready}
//   s_req     : request to the shared slave
//   s_resp    : response from the shared slave
//   dbg_state : current arbiter state
//
// Handshake: a master raises valid and holds valid/address/wdata/wstrb stable
// until it observes ready=1 for one cycle; the slave completes a transfer by
// pulsing ready=1 for one cycle while s_req valid is high. wstrb=0 is a read.
module iob_rr_merge
  import iob_rr_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  localparam int REQ_W    = req_width(ADDR_W, DATA_W),
  localparam int RESP_W   = resp_width(DATA_W)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp,
  output state_t                      dbg_state
);

  localparam int IW = idx_width(N_MASTERS);
  // Slice table padded to a power of two so gnt indexes it without range gaps.
  localparam int NP = 1 << IW;

  state_t          state, state_nxt;
  logic [IW-1:0]   gnt, gnt_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [IW-1:0]   sel;
  logic            any_req;
  logic            s_ready;
  logic [N_MASTERS-1:0] m_valid;
  logic [REQ_W-1:0]     req_arr [NP];

  for (genvar i = 0; i < NP; i++) begin : g_slice
    if (i < N_MASTERS) begin : g_real
      assign req_arr[i] = m_req[i*REQ_W +: REQ_W];
      assign m_valid[i] = m_req[valid_bit(i, REQ_W)];
      // Only the granted master sees the slave response, with no added latency.
      assign m_resp[i*RESP_W +: RESP_W] =
        (state == BUSY && gnt == IW'(i)) ? s_resp : '0;
    end else begin : g_pad
      assign req_arr[i] = '0;
    end
  end

  assign s_ready   = s_resp[0];
  assign dbg_state = state;

  // The forwarded valid is m_valid[gnt] gated by BUSY; zero in IDLE.
  assign s_req = (state == BUSY) ? req_arr[gnt] : '0;

  iob_rr_prio_sel #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_prio_sel (
    .req     (m_valid),
    .last    (last),
    .any_req (any_req),
    .sel     (sel)
  );

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        // Slave ready seen here is ignored.
        if (any_req) begin
          gnt_nxt   = sel;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Grant held until the slave answers, even if the master drops valid.
        if (s_ready) begin
          last_nxt  = gnt;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= IW'(N_MASTERS - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

endmodule
